// File: rtl/bnn_score_checker_if.sv
// bnn_score_checker_if: sample-in / result-out bundle of the BNN scoring stage.
//   master: drives in_valid, scores, vecT; observes in_ready and the result/counter outputs.
//   slave : the scoring stage itself.
//   scores packs class c at scores[c*SWIDTH +: SWIDTH]; vecT/pred are one-hot class vectors.
interface bnn_score_checker_if #(
  parameter int OWIDTH = 10,
  parameter int SWIDTH = 10,
  parameter int CWIDTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [OWIDTH*SWIDTH-1:0] scores;
  logic [OWIDTH-1:0]        vecT;
  logic                     out_valid;
  logic [OWIDTH-1:0]        pred;
  logic [CWIDTH-1:0]        pred_idx;
  logic                     hit;
  logic [CWIDTH-1:0]        n_correct;
  logic [CWIDTH-1:0]        n_total;
  logic                     done;

  modport master (
    output in_valid, scores, vecT,
    input  in_ready, out_valid, pred, pred_idx, hit, n_correct, n_total, done
  );

  modport slave (
    input  in_valid, scores, vecT,
    output in_ready, out_valid, pred, pred_idx, hit, n_correct, n_total, done
  );
endinterface

// File: rtl/bnn_score_checker.sv
// bnn_score_checker: output-side scoring stage of the pipelined BNN.
// Accepts one sample (per-class scores + one-hot target), finds the winning class
// with a sequential argmax scan (one class per cycle, lowest index wins ties),
// compares the one-hot prediction with the target and keeps hit/total counters.
// done goes high (sticky until rst) once NSAMPLES results have been produced.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset; aborts any sample and clears counters
//   bus  - bnn_score_checker_if.slave: in_valid/in_ready/scores/vecT in,
//          out_valid/pred/pred_idx/hit/n_correct/n_total/done out
module bnn_score_checker #(
  parameter int OWIDTH   = 10,
  parameter int SWIDTH   = 10,
  parameter int NSAMPLES = 10,
  parameter int CWIDTH   = 4
) (
  input logic                clk,
  input logic                rst,
  bnn_score_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    RESULT = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CWIDTH-1:0] LAST_IDX = CWIDTH'(OWIDTH - 1);
  localparam logic [CWIDTH-1:0] NS_CNT   = CWIDTH'(NSAMPLES);
  localparam logic [CWIDTH-1:0] ONE_CNT  = {{(CWIDTH-1){1'b0}}, 1'b1};

  // Mux out the score of one class; a loop-based select keeps indices in range.
  function automatic logic [SWIDTH-1:0] score_at(input logic [OWIDTH*SWIDTH-1:0] v,
                                                 input logic [CWIDTH-1:0] idx);
    logic [SWIDTH-1:0] r;
    r = '0;
    for (int c = 0; c < OWIDTH; c++) begin
      if (idx == CWIDTH'(c)) r = v[c*SWIDTH +: SWIDTH];
    end
    return r;
  endfunction

  // One-hot class vector for an index.
  function automatic logic [OWIDTH-1:0] onehot(input logic [CWIDTH-1:0] idx);
    logic [OWIDTH-1:0] r;
    r = '0;
    for (int c = 0; c < OWIDTH; c++) begin
      if (idx == CWIDTH'(c)) r[c] = 1'b1;
    end
    return r;
  endfunction

  state_t                   state, state_next;
  logic [OWIDTH*SWIDTH-1:0] scores_q;
  logic [OWIDTH-1:0]        vect_q;
  logic [SWIDTH-1:0]        best;
  logic [CWIDTH-1:0]        best_idx;
  logic [CWIDTH-1:0]        scan_idx;
  logic                     out_valid_q;
  logic [OWIDTH-1:0]        pred_q;
  logic [CWIDTH-1:0]        pred_idx_q;
  logic                     hit_q;
  logic [CWIDTH-1:0]        n_correct_q;
  logic [CWIDTH-1:0]        n_total_q;
  logic                     done_q;

  logic [SWIDTH-1:0]        cand;
  logic [OWIDTH-1:0]        pred_oh;
  logic                     hit_s;
  logic [CWIDTH-1:0]        total_next;

  assign cand       = score_at(scores_q, scan_idx);
  assign pred_oh    = onehot(best_idx);
  // Exact vector compare: all-zero or multi-hot targets can never match.
  assign hit_s      = (pred_oh == vect_q);
  assign total_next = n_total_q + ONE_CNT;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.pred      = pred_q;
  assign bus.pred_idx  = pred_idx_q;
  assign bus.hit       = hit_q;
  assign bus.n_correct = n_correct_q;
  assign bus.n_total   = n_total_q;
  assign bus.done      = done_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) state_next = SCAN;
        else              state_next = IDLE;
      end
      SCAN: begin
        if (scan_idx == LAST_IDX) state_next = RESULT;
        else                      state_next = SCAN;
      end
      RESULT: begin
        if (total_next == NS_CNT) state_next = DONE;
        else                      state_next = IDLE;
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: sample capture, argmax scan, result and counter update.
  always_ff @(posedge clk) begin
    if (rst) begin
      scores_q    <= '0;
      vect_q      <= '0;
      best        <= '0;
      best_idx    <= '0;
      scan_idx    <= '0;
      out_valid_q <= 1'b0;
      pred_q      <= '0;
      pred_idx_q  <= '0;
      hit_q       <= 1'b0;
      n_correct_q <= '0;
      n_total_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            scores_q <= bus.scores;
            vect_q   <= bus.vecT;
            best     <= score_at(bus.scores, '0);
            best_idx <= '0;
            scan_idx <= ONE_CNT;
          end
        end
        SCAN: begin
          // Strict compare: on a tie the earlier (lower) index is kept.
          if (cand > best) begin
            best     <= cand;
            best_idx <= scan_idx;
          end
          if (scan_idx != LAST_IDX) scan_idx <= scan_idx + ONE_CNT;
        end
        RESULT: begin
          pred_idx_q  <= best_idx;
          pred_q      <= pred_oh;
          hit_q       <= hit_s;
          n_total_q   <= total_next;
          n_correct_q <= n_correct_q + {{(CWIDTH-1){1'b0}}, hit_s};
          out_valid_q <= 1'b1;
          if (total_next == NS_CNT) done_q <= 1'b1;
        end
        DONE:    done_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_score_checker.sv
// tb_bnn_score_checker: directed, table-driven bench for bnn_score_checker.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bnn_score_checker;
  localparam int OW = 10;
  localparam int SW = 10;
  localparam int NS = 10;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bnn_score_checker_if #(.OWIDTH(OW), .SWIDTH(SW), .CWIDTH(CW)) bus ();

  bnn_score_checker #(.OWIDTH(OW), .SWIDTH(SW), .NSAMPLES(NS), .CWIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [OW*SW-1:0] scores;
    logic [OW-1:0]    vect;
    int               exp_idx;
    int               exp_hit;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // All classes score 'base', then class c1 gets v1 and class c2 gets v2 (c < 0 = unused).
  function automatic logic [OW*SW-1:0] mk(input int base, input int c1, input int v1,
                                          input int c2, input int v2);
    logic [OW*SW-1:0] r;
    for (int c = 0; c < OW; c++) r[c*SW +: SW] = SW'(base);
    if (c1 >= 0) r[c1*SW +: SW] = SW'(v1);
    if (c2 >= 0) r[c2*SW +: SW] = SW'(v2);
    return r;
  endfunction

  function automatic logic [OW-1:0] oh(input int idx);
    logic [OW-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait for in_ready, present one sample, then wait for out_valid.
  // lat = negedges after the accept edge until out_valid (0 = cycle after accept), -1 on timeout.
  task automatic run_one(input logic [OW*SW-1:0] sc, input logic [OW-1:0] vt, output int lat);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    bus.scores   = sc;
    bus.vecT     = vt;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int exp_total;
    int exp_correct;
    int ov_seen;
    int t_acc[NS];
    int w;

    vecs[0] = '{mk(50, 3, 100, -1, 0), 10'b0000001000, 3, 1};   // single sample
    vecs[1] = '{mk(0, 2, 400, 7, 400), oh(7),          2, 0};   // tie, miss
    vecs[2] = '{mk(0, 9, 784, 0, 783), 10'b0000000000, 9, 0};   // extremes, zero target
    vecs[3] = '{mk(784, -1, 0, -1, 0), oh(0),          0, 1};   // all equal: index 0 wins
    vecs[4] = '{mk(5, 5, 6, -1, 0),    10'b0000100001, 5, 0};   // multi-hot target
    vecs[5] = '{mk(0, 9, 1, -1, 0),    oh(9),          9, 1};   // winner is last class

    bus.in_valid = 1'b0;
    bus.scores   = '0;
    bus.vecT     = '0;

    // Reset state
    do_reset();
    chk("reset in_ready",  32'(bus.in_ready),  32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset n_total",   32'(bus.n_total),   32'd0);
    chk("reset n_correct", 32'(bus.n_correct), 32'd0);
    chk("reset done",      32'(bus.done),      32'd0);
    chk("reset pred",      32'(bus.pred),      32'd0);

    // Table-driven samples
    exp_total   = 0;
    exp_correct = 0;
    for (int k = 0; k < 6; k++) begin
      run_one(vecs[k].scores, vecs[k].vect, lat);
      exp_total++;
      exp_correct += vecs[k].exp_hit;
      chk($sformatf("v%0d latency", k),   32'(lat),           32'd10);
      chk($sformatf("v%0d pred_idx", k),  32'(bus.pred_idx),  32'(vecs[k].exp_idx));
      chk($sformatf("v%0d pred", k),      32'(bus.pred),      32'(oh(vecs[k].exp_idx)));
      chk($sformatf("v%0d hit", k),       32'(bus.hit),       32'(vecs[k].exp_hit));
      chk($sformatf("v%0d n_correct", k), 32'(bus.n_correct), 32'(exp_correct));
      chk($sformatf("v%0d n_total", k),   32'(bus.n_total),   32'(exp_total));
      chk($sformatf("v%0d in_ready", k),  32'(bus.in_ready),  32'd1);
      @(negedge clk);
      chk($sformatf("v%0d strobe width", k), 32'(bus.out_valid), 32'd0);
      chk($sformatf("v%0d pred_idx hold", k), 32'(bus.pred_idx), 32'(vecs[k].exp_idx));
    end

    // Reset in the middle of a scan after 3 results
    do_reset();
    for (int k = 0; k < 3; k++) run_one(vecs[0].scores, vecs[0].vect, lat);
    chk("pre-abort n_total", 32'(bus.n_total), 32'd3);
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    bus.scores   = vecs[1].scores;
    bus.vecT     = vecs[1].vect;
    bus.in_valid = 1'b1;
    @(posedge clk);                 // E0
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);      // now between E4 and E5
    rst = 1'b1;                     // sampled at E5
    @(negedge clk);
    chk("abort n_total",   32'(bus.n_total),   32'd0);
    chk("abort n_correct", 32'(bus.n_correct), 32'd0);
    chk("abort in_ready",  32'(bus.in_ready),  32'd1);
    rst = 1'b0;
    ov_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid) ov_seen++;
      @(negedge clk);
    end
    chk("abort no out_valid", 32'(ov_seen), 32'd0);
    run_one(vecs[0].scores, vecs[0].vect, lat);
    chk("post-abort latency", 32'(lat),         32'd10);
    chk("post-abort n_total", 32'(bus.n_total), 32'd1);
    chk("post-abort hit",     32'(bus.hit),     32'd1);

    // Full run: in_valid held high, 10 samples, 6 hits
    do_reset();
    bus.in_valid = 1'b1;
    for (int k = 0; k < NS; k++) begin
      w = 0;
      while (!bus.in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      bus.scores = mk(20, k, 500, -1, 0);
      bus.vecT   = (k < 6) ? oh(k) : oh((k + 1) % OW);
      t_acc[k]   = cyc;
      @(posedge clk);
      @(negedge clk);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("run%0d out_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("run%0d pred_idx", k),  32'(bus.pred_idx),  32'(k));
      chk($sformatf("run%0d hit", k),       32'(bus.hit),       (k < 6) ? 32'd1 : 32'd0);
      chk($sformatf("run%0d done", k),      32'(bus.done),      (k == NS - 1) ? 32'd1 : 32'd0);
      if (k > 0) chk($sformatf("run%0d accept spacing", k), 32'(t_acc[k] - t_acc[k-1]), 32'd11);
    end
    chk("run final n_total",   32'(bus.n_total),   32'd10);
    chk("run final n_correct", 32'(bus.n_correct), 32'd6);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("done in_ready low", 32'(bus.in_ready), 32'd0);
      chk("done sticky",       32'(bus.done),     32'd1);
    end
    chk("done n_total held", 32'(bus.n_total), 32'd10);
    bus.in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
